// File: rtl/traffic_manual_panel.sv
// Operator panel for traffic_light_controller: two debounced push-buttons drive a
// small mode FSM that issues manual_override / manual_state, with an idle auto-release.

module traffic_manual_panel_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic          r_deb_prev;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '0;
      r_deb      <= 1'b0;
      r_deb_prev <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync     <= {r_sync[0], i_raw};
      r_deb_prev <= r_deb;
      // flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
      if (r_sync[1] != r_deb) begin
        if (r_cnt == CMAX) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_deb & ~r_deb_prev;
endmodule

module traffic_manual_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_TIMEOUT    = 60,
  parameter int TO_W            = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_override_raw,
  input  logic            btn_next_raw,
  output logic            manual_override,
  output logic [1:0]      manual_state,
  output logic [TO_W-1:0] hold_remaining,
  output logic            timeout_evt
);
  typedef enum logic [1:0] {S_AUTO, S_RED, S_GRN, S_YEL} state_t;

  localparam bit TO_EN = (HOLD_TIMEOUT != 0);
  localparam logic [TO_W-1:0] IDLE_MAX = TO_EN ? TO_W'(HOLD_TIMEOUT - 1) : '0;

  logic [1:0]      w_raw;
  logic [1:0]      w_press;
  logic            w_ov;
  logic            w_nx;
  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_idle;
  logic [TO_W-1:0] w_idle_nxt;
  logic            r_timeout;
  logic            w_fire;

  assign w_raw = {btn_next_raw, btn_override_raw};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    traffic_manual_panel_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_raw[g]),
      .o_press (w_press[g])
    );
  end

  assign w_ov = w_press[0];
  assign w_nx = w_press[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_AUTO;
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_idle    <= w_idle_nxt;
      r_timeout <= w_fire;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_fire     = 1'b0;
    w_idle_nxt = r_idle;
    case (r_state)
      S_AUTO: if (w_ov) w_next = S_RED;
      default: begin
        // override beats next; any press beats the timeout
        if (w_ov) begin
          w_next = S_AUTO;
        end else if (w_nx) begin
          case (r_state)
            S_RED:   w_next = S_GRN;
            S_GRN:   w_next = S_YEL;
            default: w_next = S_RED;
          endcase
        end else if (TO_EN && r_idle == IDLE_MAX) begin
          w_next = S_AUTO;
          w_fire = 1'b1;
        end
      end
    endcase
    if (w_next == S_AUTO || r_state == S_AUTO || w_ov || w_nx)
      w_idle_nxt = '0;
    else if (r_idle != IDLE_MAX)
      w_idle_nxt = r_idle + 1'b1;
  end

  always_comb begin
    manual_override = (r_state != S_AUTO);
    case (r_state)
      S_GRN:   manual_state = 2'b10;
      S_YEL:   manual_state = 2'b01;
      default: manual_state = 2'b00;
    endcase
    hold_remaining = (TO_EN && r_state != S_AUTO) ? (IDLE_MAX - r_idle) : '0;
    timeout_evt    = r_timeout;
  end
endmodule
